// File: rtl/squash_gen.sv
// Commit-side squash packet generator: records branch mispredictions and the oldest
// memory-order violation per robIdx, and fires a one-cycle registered squash when the culprit retires.
module squash_gen #(
    parameter int ROB_SIZE = 64,
    parameter int XLEN     = 64,
    parameter int FOLDPC_W = 10,
    parameter int WB_PORTS = 2,
    localparam int IW      = $clog2(ROB_SIZE),
    localparam int RW      = IW + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WB_PORTS-1:0]        i_wb_vld,
    input  logic [WB_PORTS*RW-1:0]     i_wb_rob_idx,
    input  logic [WB_PORTS-1:0]        i_wb_mispred,
    input  logic [WB_PORTS-1:0]        i_wb_taken,
    input  logic [WB_PORTS*XLEN-1:0]   i_wb_npc,
    input  logic                       i_viol_vld,
    input  logic [RW-1:0]              i_viol_rob_idx,
    input  logic [XLEN-1:0]            i_viol_pc,
    input  logic [FOLDPC_W-1:0]        i_viol_store_foldpc,
    input  logic [FOLDPC_W-1:0]        i_viol_load_foldpc,
    input  logic                       i_commit_vld,
    input  logic [RW-1:0]              i_commit_rob_idx,
    output logic                       o_squash_vld,
    output logic                       o_squash_due_to_branch,
    output logic                       o_squash_due_to_violation,
    output logic                       o_squash_branch_taken,
    output logic [XLEN-1:0]            o_squash_arch_pc,
    output logic [FOLDPC_W-1:0]        o_squash_store_foldpc,
    output logic [FOLDPC_W-1:0]        o_squash_load_foldpc
);

    typedef enum logic {S_IDLE, S_SQUASH} state_t;

    state_t                r_state;
    logic [ROB_SIZE-1:0]   r_mp_vld;
    logic                  r_mp_taken [ROB_SIZE];
    logic [XLEN-1:0]       r_mp_npc   [ROB_SIZE];
    logic                  r_viol_vld;
    logic [RW-1:0]         r_viol_rob_idx;
    logic [XLEN-1:0]       r_viol_pc;
    logic [FOLDPC_W-1:0]   r_viol_sfp;
    logic [FOLDPC_W-1:0]   r_viol_lfp;

    logic                  r_sq_vld;
    logic                  r_sq_br;
    logic                  r_sq_viol;
    logic                  r_sq_taken;
    logic [XLEN-1:0]       r_sq_pc;
    logic [FOLDPC_W-1:0]   r_sq_sfp;
    logic [FOLDPC_W-1:0]   r_sq_lfp;

    logic [IW-1:0]         w_head;
    logic                  w_viol_hit;
    logic                  w_fire;
    logic                  w_accept;
    logic                  w_viol_take;
    logic                  w_unused_flags;

    // Age compare across the wrap flag: a is older than b.
    function automatic logic older(input logic [RW-1:0] a, input logic [RW-1:0] b);
        if (a[RW-1] != b[RW-1])
            return a[IW-1:0] > b[IW-1:0];
        else
            return a[IW-1:0] < b[IW-1:0];
    endfunction

    assign w_head      = i_commit_rob_idx[IW-1:0];
    assign w_viol_hit  = r_viol_vld && (r_viol_rob_idx == i_commit_rob_idx);
    assign w_fire      = (r_state == S_IDLE) && i_commit_vld && (w_viol_hit || r_mp_vld[w_head]);
    // Nothing is captured during the squash cycle or the cycle that triggers it.
    assign w_accept    = (r_state == S_IDLE) && !w_fire;
    assign w_viol_take = w_accept && i_viol_vld &&
                         (!r_viol_vld || older(i_viol_rob_idx, r_viol_rob_idx));

    // The table is addressed by the low index bits only; wrap flags of writebacks are not needed.
    always_comb begin
        w_unused_flags = 1'b0;
        for (int p = 0; p < WB_PORTS; p++)
            w_unused_flags = w_unused_flags ^ i_wb_rob_idx[p*RW+IW];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_mp_vld   <= '0;
            r_viol_vld <= 1'b0;
            r_sq_vld   <= 1'b0;
            r_sq_br    <= 1'b0;
            r_sq_viol  <= 1'b0;
            r_sq_taken <= 1'b0;
            r_sq_pc    <= '0;
            r_sq_sfp   <= '0;
            r_sq_lfp   <= '0;
        end else begin
            r_sq_vld   <= 1'b0;
            r_sq_br    <= 1'b0;
            r_sq_viol  <= 1'b0;
            r_sq_taken <= 1'b0;
            r_sq_pc    <= '0;
            r_sq_sfp   <= '0;
            r_sq_lfp   <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_fire) begin
                        r_state    <= S_SQUASH;
                        r_mp_vld   <= '0;
                        r_viol_vld <= 1'b0;
                        r_sq_vld   <= 1'b1;
                        if (w_viol_hit) begin
                            r_sq_viol <= 1'b1;
                            r_sq_pc   <= r_viol_pc;
                            r_sq_sfp  <= r_viol_sfp;
                            r_sq_lfp  <= r_viol_lfp;
                        end else begin
                            r_sq_br    <= 1'b1;
                            r_sq_taken <= r_mp_taken[w_head];
                            r_sq_pc    <= r_mp_npc[w_head];
                        end
                    end else begin
                        if (i_commit_vld)
                            r_mp_vld[w_head] <= 1'b0;
                        for (int p = 0; p < WB_PORTS; p++) begin
                            if (i_wb_vld[p] && i_wb_mispred[p])
                                r_mp_vld[i_wb_rob_idx[p*RW +: IW]] <= 1'b1;
                        end
                        if (w_viol_take)
                            r_viol_vld <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int p = 0; p < WB_PORTS; p++) begin
                if (i_wb_vld[p] && i_wb_mispred[p]) begin
                    r_mp_taken[i_wb_rob_idx[p*RW +: IW]] <= i_wb_taken[p];
                    r_mp_npc[i_wb_rob_idx[p*RW +: IW]]   <= i_wb_npc[p*XLEN +: XLEN];
                end
            end
        end
        if (w_viol_take) begin
            r_viol_rob_idx <= i_viol_rob_idx;
            r_viol_pc      <= i_viol_pc;
            r_viol_sfp     <= i_viol_store_foldpc;
            r_viol_lfp     <= i_viol_load_foldpc;
        end
    end

    assign o_squash_vld              = r_sq_vld;
    assign o_squash_due_to_branch    = r_sq_br;
    assign o_squash_due_to_violation = r_sq_viol;
    assign o_squash_branch_taken     = r_sq_taken;
    assign o_squash_arch_pc          = r_sq_pc;
    assign o_squash_store_foldpc     = r_sq_sfp;
    assign o_squash_load_foldpc      = r_sq_lfp;

endmodule

// File: tb/tb_squash_gen.sv
// Scoreboard bench for squash_gen: directed scenarios plus random traffic against a queue/array model.
module tb_squash_gen;

    localparam int ROB  = 64;
    localparam int RW   = 7;
    localparam int XLEN = 64;
    localparam int FW   = 10;
    localparam int WP   = 2;

    logic                clk;
    logic                rst;
    logic [WP-1:0]       wb_vld, wb_mp, wb_tk;
    logic [WP*RW-1:0]    wb_idx;
    logic [WP*XLEN-1:0]  wb_npc;
    logic                v_vld;
    logic [RW-1:0]       v_idx;
    logic [XLEN-1:0]     v_pc;
    logic [FW-1:0]       v_sf, v_lf;
    logic                c_vld;
    logic [RW-1:0]       c_idx;
    logic                o_vld, o_br, o_vi, o_tk;
    logic [XLEN-1:0]     o_pc;
    logic [FW-1:0]       o_sf, o_lf;

    squash_gen #(.ROB_SIZE(ROB), .XLEN(XLEN), .FOLDPC_W(FW), .WB_PORTS(WP)) dut (
        .clk(clk), .rst(rst),
        .i_wb_vld(wb_vld), .i_wb_rob_idx(wb_idx), .i_wb_mispred(wb_mp),
        .i_wb_taken(wb_tk), .i_wb_npc(wb_npc),
        .i_viol_vld(v_vld), .i_viol_rob_idx(v_idx), .i_viol_pc(v_pc),
        .i_viol_store_foldpc(v_sf), .i_viol_load_foldpc(v_lf),
        .i_commit_vld(c_vld), .i_commit_rob_idx(c_idx),
        .o_squash_vld(o_vld), .o_squash_due_to_branch(o_br),
        .o_squash_due_to_violation(o_vi), .o_squash_branch_taken(o_tk),
        .o_squash_arch_pc(o_pc), .o_squash_store_foldpc(o_sf), .o_squash_load_foldpc(o_lf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int              cyc;
        bit              br;
        bit              vi;
        bit              tk;
        logic [XLEN-1:0] pc;
        logic [FW-1:0]   sf;
        logic [FW-1:0]   lf;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // Reference state: per-index mispredict records and the single oldest violation.
    bit              m_mp    [ROB];
    bit              m_tk    [ROB];
    logic [XLEN-1:0] m_npc   [ROB];
    bit              mv_vld;
    int              mv_idx;
    logic [XLEN-1:0] mv_pc;
    logic [FW-1:0]   mv_sf, mv_lf;
    bit              m_busy;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Distance modulo twice the ROB size: strictly more than half a lap behind means older.
    function automatic bit m_older(input int a, input int b);
        return ((a - b + 2*ROB) % (2*ROB)) > ROB;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ROB; i++) m_mp[i] = 0;
        mv_vld = 0;
        m_busy = 0;
    endtask

    task automatic model_step();
        exp_t e;
        int   h;
        h = int'(c_idx) % ROB;
        if (m_busy) begin
            m_busy = 0;
        end else if (c_vld && (mv_vld && mv_idx == int'(c_idx) || m_mp[h])) begin
            e.cyc = cyc + 1;
            if (mv_vld && mv_idx == int'(c_idx)) begin
                e.br = 0; e.vi = 1; e.tk = 0; e.pc = mv_pc; e.sf = mv_sf; e.lf = mv_lf;
            end else begin
                e.br = 1; e.vi = 0; e.tk = m_tk[h]; e.pc = m_npc[h]; e.sf = '0; e.lf = '0;
            end
            sb_q.push_back(e);
            for (int i = 0; i < ROB; i++) m_mp[i] = 0;
            mv_vld = 0;
            m_busy = 1;
        end else begin
            if (c_vld) m_mp[h] = 0;
            for (int p = 0; p < WP; p++) begin
                if (wb_vld[p] && wb_mp[p]) begin
                    int k;
                    k = int'(wb_idx[p*RW +: RW]) % ROB;
                    m_mp[k]  = 1;
                    m_tk[k]  = wb_tk[p];
                    m_npc[k] = wb_npc[p*XLEN +: XLEN];
                end
            end
            if (v_vld && (!mv_vld || m_older(int'(v_idx), mv_idx))) begin
                mv_vld = 1; mv_idx = int'(v_idx); mv_pc = v_pc; mv_sf = v_sf; mv_lf = v_lf;
            end
        end
    endtask

    task automatic clear_inputs();
        wb_vld = '0; wb_mp = '0; wb_tk = '0; wb_idx = '0; wb_npc = '0;
        v_vld = 0; v_idx = '0; v_pc = '0; v_sf = '0; v_lf = '0;
        c_vld = 0; c_idx = '0;
    endtask

    task automatic set_wb(input int p, input int idx, input bit mp, input bit tk, input logic [XLEN-1:0] npc);
        wb_vld[p] = 1; wb_mp[p] = mp; wb_tk[p] = tk;
        wb_idx[p*RW +: RW] = RW'(idx);
        wb_npc[p*XLEN +: XLEN] = npc;
    endtask

    task automatic set_viol(input int idx, input logic [XLEN-1:0] pc, input int sf, input int lf);
        v_vld = 1; v_idx = RW'(idx); v_pc = pc; v_sf = FW'(sf); v_lf = FW'(lf);
    endtask

    task automatic set_commit(input int idx);
        c_vld = 1; c_idx = RW'(idx);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    // Monitor: on every falling edge, decide from the scoreboard whether a squash is due now.
    always @(negedge clk) begin
        if (rst) begin
            bit   due;
            exp_t e;
            while (sb_q.size() > 0 && sb_q[0].cyc < cyc) void'(sb_q.pop_front());
            due = (sb_q.size() > 0 && sb_q[0].cyc == cyc);
            chk("squash_vld", 64'(o_vld), 64'(due));
            if (due) begin
                e = sb_q.pop_front();
                chk("due_to_branch", 64'(o_br), 64'(e.br));
                chk("due_to_violation", 64'(o_vi), 64'(e.vi));
                chk("branch_taken", 64'(o_tk), 64'(e.tk));
                chk("arch_pc", o_pc, e.pc);
                chk("store_foldpc", 64'(o_sf), 64'(e.sf));
                chk("load_foldpc", 64'(o_lf), 64'(e.lf));
            end else begin
                chk("idle_flags", 64'({o_br, o_vi, o_tk}), 64'(0));
                chk("idle_payload", o_pc | 64'(o_sf) | 64'(o_lf), 64'(0));
            end
        end
    end

    initial begin
        int last_wb;
        int last_v;
        clear_inputs();
        model_reset();
        rst = 0;
        #1;
        chk("reset_vld", 64'(o_vld), 64'(0));
        chk("reset_pc", o_pc, 64'(0));
        #11;
        rst = 1;
        @(posedge clk); #1;

        // Mispredicted branch retires; a later-lap commit of the same slot stays quiet.
        set_wb(0, 5, 1, 1, 64'h8000_1000); tick();
        set_commit(5); tick();
        tick();
        set_commit(5 + ROB); tick();
        tick();

        // Older violation replaces a younger one.
        set_viol(9, 64'h2040, 'h3A, 'h11); tick();
        set_viol(7, 64'h1F00, 'h05, 'h22); tick();
        set_commit(7); tick();
        tick();

        // Wrap-flag age: {0,60} is older than {1,3}.
        set_viol(ROB + 3, 64'h3000, 'h101, 'h0F0); tick();
        set_viol(60, 64'h4444, 'h2AA, 'h155); tick();
        set_commit(60); tick();
        tick();

        // Violation outranks a mispredict on the same slot.
        set_wb(1, 4, 1, 1, 64'hDEAD_BEEF); set_viol(4, 64'h5000, 'h1, 'h2); tick();
        set_commit(4); tick();
        tick();

        // Writebacks during the trigger and squash cycles are dropped.
        set_wb(0, 10, 1, 0, 64'h1234); tick();
        set_commit(10); set_wb(1, 6, 1, 1, 64'h6666); tick();
        set_wb(0, 6, 1, 1, 64'h7777); tick();
        tick();
        set_commit(6); tick();
        tick();

        // Correctly predicted branch leaves nothing behind.
        set_wb(0, 2, 0, 1, 64'h2222); tick();
        set_commit(2); tick();
        tick();

        last_wb = 0;
        last_v  = 0;
        for (int n = 0; n < 1500; n++) begin
            for (int p = 0; p < WP; p++) begin
                if ($urandom_range(0, 99) < 35) begin
                    int idx;
                    idx = $urandom_range(0, 2*ROB - 1);
                    set_wb(p, idx, ($urandom_range(0, 99) < 60), 1'($urandom), {$urandom, $urandom});
                    last_wb = idx;
                end
            end
            if ($urandom_range(0, 99) < 15) begin
                last_v = $urandom_range(0, 2*ROB - 1);
                set_viol(last_v, {$urandom, $urandom}, $urandom_range(0, 1023), $urandom_range(0, 1023));
            end
            if ($urandom_range(0, 99) < 40) begin
                case ($urandom_range(0, 2))
                    0: set_commit(last_wb);
                    1: set_commit(last_v);
                    default: set_commit($urandom_range(0, 2*ROB - 1));
                endcase
                for (int p = 0; p < WP; p++)
                    if (wb_vld[p] && wb_idx[p*RW +: 6] == c_idx[5:0]) wb_vld[p] = 0;
            end
            tick();
        end
        repeat (3) tick();

        // Reset asserted while the squash pulse is high clears the outputs immediately.
        set_wb(0, 20, 1, 1, 64'hABC); tick();
        set_commit(20);
        model_step();
        @(posedge clk); #1;
        clear_inputs();
        chk("pre_reset_vld", 64'(o_vld), 64'(1));
        sb_q.delete();
        rst = 0;
        #1;
        chk("async_reset_vld", 64'(o_vld), 64'(0));
        chk("async_reset_flags", 64'({o_br, o_vi, o_tk}), 64'(0));
        chk("async_reset_pc", o_pc, 64'(0));
        model_reset();
        #2;
        rst = 1;
        @(posedge clk); #1;
        set_commit(20); tick();
        repeat (3) tick();

        chk("scoreboard_drained", 64'(sb_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/squash_gen.md
Name: squash_gen

Overview:
- Commit-side producer of the squash packet (dueToBranch, dueToViolation, branch_taken, arch_pc, store_foldpc, load_foldpc) sent from the ROB to the frontend and FTQ.
- Captures branch writebacks and memory-order violations per ROB index.
- Emits a one-cycle registered squash pulse only when the offending instruction reaches the ROB head and retires.
- Sits beside the ROB, between the BRU/LSU writeback buses and the redirect path.

Parameters:
- ROB_SIZE, 64: ROB entries, power of two. robIdx width RW = log2(ROB_SIZE)+1 (MSB is the wrap flag).
- XLEN, 64: PC width.
- FOLDPC_W, 10: folded-PC width for memory-dependence training.
- WB_PORTS, 2: branch writeback ports.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- i_wb_vld  in  WB_PORTS  per-port branch writeback valid
- i_wb_rob_idx  in  WB_PORTS*RW  robIdx per port
- i_wb_mispred  in  WB_PORTS  branch mispredicted
- i_wb_taken  in  WB_PORTS  branch actually taken
- i_wb_npc  in  WB_PORTS*XLEN  correct next PC (branch_npc)
- i_viol_vld  in  1  load violation report
- i_viol_rob_idx  in  RW  violating load robIdx
- i_viol_pc  in  XLEN  load PC (refetch target)
- i_viol_store_foldpc  in  FOLDPC_W  store folded PC
- i_viol_load_foldpc  in  FOLDPC_W  load folded PC
- i_commit_vld  in  1  ROB head retires this cycle
- i_commit_rob_idx  in  RW  head robIdx
- o_squash_vld  out  1  squash pulse
- o_squash_due_to_branch  out  1
- o_squash_due_to_violation  out  1
- o_squash_branch_taken  out  1
- o_squash_arch_pc  out  XLEN
- o_squash_store_foldpc  out  FOLDPC_W
- o_squash_load_foldpc  out  FOLDPC_W

Behaviour:
- Reset (rst=0, async):
  - All outputs 0.
  - All table valid bits 0.
  - Pending violation invalid.
  - FSM = IDLE.
- Mispred table: ROB_SIZE entries of {mp_vld, taken, npc}, indexed by robIdx low bits.
  - i_wb_vld[p] & i_wb_mispred[p] sets mp_vld and writes taken/npc.
  - A correctly predicted writeback writes nothing.
  - Two ports hitting the same index in one cycle is a protocol violation; the higher port number wins.
- Violation register: one entry holding {vld, rob_idx, pc, store_foldpc, load_foldpc}.
  - A new report is captured if the register is empty or the new robIdx is older.
  - Older(a,b) = (a.flag != b.flag) ? (a.low > b.low) : (a.low < b.low).
  - Equal index: keep the existing entry.
- FSM IDLE, on i_commit_vld with head index h:
  - If the violation register is valid and rob_idx == h: squash with due_to_violation=1, branch_taken=0, arch_pc=viol pc, foldpcs from the register.
    - This takes priority over a mispred entry at h.
  - Else if table[h].mp_vld: squash with due_to_branch=1, branch_taken=table.taken, arch_pc=table.npc, foldpcs=0.
  - Else: no squash; clear table[h].mp_vld.
  - On squash: outputs are registered (visible cycle T+1); at the T edge, clear the whole table and the violation register; FSM goes to SQUASH.
- FSM SQUASH (exactly one cycle):
  - o_squash_vld=1.
  - All wb, viol and commit inputs are ignored (in-flight wrong-path results).
  - Return to IDLE; o_squash_vld and all payload fields drop to 0.
- Wb and viol inputs in cycle T (the commit cycle that triggers a squash) are also dropped.
- Table lookup uses registered state only. A writeback to h in the same cycle as the commit of h is a protocol violation (bench assertion); lookup sees the pre-write value.
- Latency: commit to o_squash_vld is 1 cycle. Minimum spacing between squashes is 2 cycles.
- Reset asserted during SQUASH: outputs go to 0 immediately, no residual pulse.

Test Plan:
- Port0 wb idx=5, mispred=1, taken=1, npc=0x8000_1000; commit idx=5 at cycle T -> T+1: o_squash_vld=1, due_to_branch=1, branch_taken=1, arch_pc=0x8000_1000; T+2: vld=0; a later commit of idx=5 (next lap) gives no squash.
- Viol idx=9, pc=0x2040, store_foldpc=0x3A, load_foldpc=0x11, then viol idx=7 -> register keeps 7. Commit 7 -> due_to_violation=1, arch_pc from the idx-7 report, foldpcs from the idx-7 report.
- Wrap age check: viol idx={1,3} then {0,60} -> {0,60} is retained as older.
- Mispred wb at idx=4 and viol at idx=4, commit 4 -> violation wins, branch_taken=0.
- Squash at T; wb mispred idx=6 at T and T+1; commit 6 at T+3 -> no squash.
- Correct-pred wb idx=2 (mispred=0), commit 2 -> no squash; rst pulse mid-SQUASH -> all outputs 0 asynchronously.
